// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, bit-count type and ACK/NACK line levels.
package i2c_pkg;

  localparam int unsigned BitCntW = 4;
  typedef logic [BitCntW-1:0] bit_cnt_t;

  localparam bit_cnt_t LastBit  = bit_cnt_t'(7);
  localparam bit_cnt_t ByteDone = bit_cnt_t'(8);
  localparam bit_cnt_t AckDone  = bit_cnt_t'(9);

  localparam logic AckBit  = 1'b0;
  localparam logic NackBit = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } i2c_state_e;

  // States in which the slave owns the 9th (ACK) bit.
  function automatic logic is_slave_ack_state(input i2c_state_e st);
    return (st == StAddrAck) || (st == StPtrAck) || (st == StWdataAck);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter; output follows the input only after
// FILTER_LEN consecutive equal samples, so input-to-output latency is 2+FILTER_LEN clocks.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic            sync1_q;
  logic            sync2_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      cnt_q    <= '0;
      line_out <= 1'b1;
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      if (sync2_q == line_out) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        line_out <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave bridging a 7-bit bus address to a simple register file through an auto-incrementing
// pointer; no clock stretching, SDA driven open-drain via sda_oe.
module i2c_slave_regfile import i2c_pkg::*; #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned FILTER_LEN = 3,
  localparam int unsigned AW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic [AW-1:0] reg_addr,
  output logic          reg_wr_en,
  output logic [7:0]    reg_wr_data,
  output logic          reg_rd_en,
  input  logic [7:0]    reg_rd_data,
  output logic          busy
);

  logic       scl_f, sda_f;
  logic       scl_prev_q, sda_prev_q;
  i2c_state_e state_q;
  bit_cnt_t   bit_cnt_q;
  logic [7:0] sr_q, tx_q, sr_next;
  logic       rw_q, rd_cap_q;
  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (scl_in),
    .line_out(scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .line_in (sda_in),
    .line_out(sda_f)
  );

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (32'(p) == NUM_REGS - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    scl_rise  = scl_f & ~scl_prev_q;
    scl_fall  = ~scl_f & scl_prev_q;
    start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
    sr_next   = {sr_q[6:0], sda_f};
    last_bit  = (bit_cnt_q == LastBit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      rd_cap_q    <= 1'b0;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      sda_oe      <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      reg_wr_en  <= 1'b0;
      reg_rd_en  <= 1'b0;
      // Register file returns data one clock after the read strobe.
      rd_cap_q   <= reg_rd_en;
      if (rd_cap_q) tx_q <= reg_rd_data;
      if (reg_wr_en) reg_addr <= ptr_next(reg_addr);

      if (start_det) begin
        state_q   <= StAddr;
        bit_cnt_q <= '0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          StAddr: begin
            sr_q      <= sr_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              if (sr_next[7:1] == SLAVE_ADDR) begin
                state_q <= StAddrAck;
                rw_q    <= sr_next[0];
                busy    <= 1'b1;
              end else begin
                state_q <= StWaitStop;
                busy    <= 1'b0;
              end
            end
          end
          StPtr: begin
            sr_q      <= sr_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              if (32'(sr_next) < NUM_REGS) begin
                reg_addr <= sr_next[AW-1:0];
                state_q  <= StPtrAck;
              end else begin
                state_q <= StWaitStop;
                busy    <= 1'b0;
              end
            end
          end
          StWdata: begin
            sr_q      <= sr_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) begin
              reg_wr_en   <= 1'b1;
              reg_wr_data <= sr_next;
              state_q     <= StWdataAck;
            end
          end
          StAddrAck, StPtrAck, StWdataAck: begin
            bit_cnt_q <= AckDone;
            if (state_q == StAddrAck && rw_q) reg_rd_en <= 1'b1;
          end
          StRdata: begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (last_bit) reg_addr <= ptr_next(reg_addr);
          end
          StRdataAck: begin
            if (sda_f == NackBit) begin
              state_q <= StWaitStop;
              busy    <= 1'b0;
            end else begin
              reg_rd_en <= 1'b1;
              bit_cnt_q <= AckDone;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        if (is_slave_ack_state(state_q)) begin
          if (bit_cnt_q == ByteDone) begin
            sda_oe <= ~AckBit;
          end else if (bit_cnt_q == AckDone) begin
            bit_cnt_q <= '0;
            if (state_q == StAddrAck && rw_q) begin
              state_q <= StRdata;
              sda_oe  <= ~tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b0};
            end else begin
              sda_oe  <= 1'b0;
              state_q <= (state_q == StAddrAck) ? StPtr : StWdata;
            end
          end
        end else if (state_q == StRdata) begin
          if (bit_cnt_q == ByteDone) begin
            sda_oe  <= 1'b0;
            state_q <= StRdataAck;
          end else begin
            sda_oe <= ~tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end else if (state_q == StRdataAck && bit_cnt_q == AckDone) begin
          bit_cnt_q <= '0;
          state_q   <= StRdata;
          sda_oe    <= ~tx_q[7];
          tx_q      <= {tx_q[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master driven from a vector table,
// plus a hand-written reset-during-read sequence.
module tb_i2c_slave_regfile;
  import i2c_pkg::*;

  localparam int unsigned NumRegs = 16;
  localparam int unsigned FiltLen = 3;
  localparam int unsigned Aw      = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl_m = 1'b1;
  logic          sda_m = 1'b1;
  logic          scl_in, sda_in, sda_oe, reg_wr_en, reg_rd_en, busy;
  logic [Aw-1:0] reg_addr;
  logic [7:0]    reg_wr_data, reg_rd_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .SLAVE_ADDR(7'h42),
    .NUM_REGS  (NumRegs),
    .FILTER_LEN(FiltLen)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_data(reg_wr_data),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .busy       (busy)
  );

  // Register file model: registered read, data valid the clock after reg_rd_en.
  logic [7:0] mem [NumRegs];
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
  end

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  wr_t wlog[$];
  int  wr_total = 0, rd_total = 0, oe_total = 0;
  always @(posedge clk) begin
    if (reg_wr_en) begin
      wr_total = wr_total + 1;
      wlog.push_back({reg_addr, reg_wr_data});
    end
    if (reg_rd_en) rd_total = rd_total + 1;
    if (sda_oe) oe_total = oe_total + 1;
  end

  typedef enum {OpStart, OpStop, OpWr, OpWrG, OpRd, OpPtr, OpBusy, OpWlog, OpSnap, OpQuiet} op_e;
  typedef struct {
    op_e        op;
    string      nm;
    logic [7:0] d;
    logic       x;
    logic [3:0] a;
  } vec_t;
  vec_t vecs[$];

  int n_vec = 0, n_fail = 0, wlog_idx = 0;
  int snap_wr, snap_rd, snap_oe;

  function automatic void add(input op_e op, input string nm, input logic [7:0] d = 8'h00,
                              input logic x = 1'b0, input logic [3:0] a = 4'h0);
    vec_t v;
    v.op = op; v.nm = nm; v.d = d; v.x = x; v.a = a;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      wait_clks(4);
      scl_m = 1'b1;
      wait_clks(FiltLen - 1);
      scl_m = 1'b0;
      wait_clks(6 - (FiltLen - 1));
    end else begin
      wait_clks(10);
    end
    scl_m = 1'b1;
    wait_clks(20);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(10);
    b = sda_in;
    wait_clks(10);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 4));
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~mack, 1'b0);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(20);
    sda_m = 1'b0;
    wait_clks(20);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(20);
    sda_m = 1'b1;
    wait_clks(20);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       ack, b;
    logic [7:0] rd;
    vec_t       v;

    // Write 0xA5, 0x5A starting at register 3.
    add(OpStart, "w.start");
    add(OpWr, "w.addr_ack", 8'h84, 1'b1);
    add(OpWr, "w.ptr_ack", 8'h03, 1'b1);
    add(OpWr, "w.d0_ack", 8'hA5, 1'b1);
    add(OpBusy, "w.busy_mid", 8'h00, 1'b1);
    add(OpWr, "w.d1_ack", 8'h5A, 1'b1);
    add(OpStop, "w.stop");
    add(OpBusy, "w.busy_end", 8'h00, 1'b0);
    add(OpWlog, "w.strobe0", 8'hA5, 1'b0, 4'd3);
    add(OpWlog, "w.strobe1", 8'h5A, 1'b0, 4'd4);
    add(OpPtr, "w.ptr_final", 8'h00, 1'b0, 4'd5);
    // Write across the top register: 15 -> 0 wrap.
    add(OpStart, "wrap.start");
    add(OpWr, "wrap.addr_ack", 8'h84, 1'b1);
    add(OpWr, "wrap.ptr_ack", 8'h0F, 1'b1);
    add(OpWr, "wrap.d0_ack", 8'h11, 1'b1);
    add(OpWr, "wrap.d1_ack", 8'h22, 1'b1);
    add(OpStop, "wrap.stop");
    add(OpWlog, "wrap.strobe0", 8'h11, 1'b0, 4'd15);
    add(OpWlog, "wrap.strobe1", 8'h22, 1'b0, 4'd0);
    add(OpPtr, "wrap.ptr_final", 8'h00, 1'b0, 4'd1);
    // Set pointer, repeated START, read two bytes with wrap.
    add(OpStart, "r.start");
    add(OpWr, "r.addr_ack", 8'h84, 1'b1);
    add(OpWr, "r.ptr_ack", 8'h0F, 1'b1);
    add(OpStart, "r.rstart");
    add(OpWr, "r.raddr_ack", 8'h85, 1'b1);
    add(OpBusy, "r.busy_mid", 8'h00, 1'b1);
    add(OpRd, "r.byte0", 8'h11, 1'b1);
    add(OpRd, "r.byte1", 8'h22, 1'b0);
    add(OpBusy, "r.busy_nack", 8'h00, 1'b0);
    add(OpStop, "r.stop");
    add(OpBusy, "r.busy_end", 8'h00, 1'b0);
    add(OpPtr, "r.ptr_final", 8'h00, 1'b0, 4'd1);
    // Foreign address: silent.
    add(OpSnap, "mm.snap");
    add(OpStart, "mm.start");
    add(OpWr, "mm.addr_nack", 8'h86, 1'b0);
    add(OpBusy, "mm.busy", 8'h00, 1'b0);
    add(OpStop, "mm.stop");
    add(OpQuiet, "mm.quiet");
    // Pointer out of range: NACK, following data ignored.
    add(OpStart, "bp.start");
    add(OpWr, "bp.addr_ack", 8'h84, 1'b1);
    add(OpWr, "bp.ptr_nack", 8'h10, 1'b0);
    add(OpBusy, "bp.busy", 8'h00, 1'b0);
    add(OpSnap, "bp.snap");
    add(OpWr, "bp.data_nack", 8'h77, 1'b0);
    add(OpStop, "bp.stop");
    add(OpQuiet, "bp.quiet");
    add(OpPtr, "bp.ptr_kept", 8'h00, 1'b0, 4'd1);
    // Preload register 5 for the reset test.
    add(OpStart, "pl.start");
    add(OpWr, "pl.addr_ack", 8'h84, 1'b1);
    add(OpWr, "pl.ptr_ack", 8'h05, 1'b1);
    add(OpWr, "pl.d_ack", 8'hE7, 1'b1);
    add(OpStop, "pl.stop");
    add(OpWlog, "pl.strobe", 8'hE7, 1'b0, 4'd5);
    // SCL glitch of FILTER_LEN-1 clocks inside a data byte.
    add(OpStart, "g.start");
    add(OpWr, "g.addr_ack", 8'h84, 1'b1);
    add(OpWr, "g.ptr_ack", 8'h02, 1'b1);
    add(OpWrG, "g.d_ack", 8'hC3, 1'b1);
    add(OpStop, "g.stop");
    add(OpWlog, "g.strobe", 8'hC3, 1'b0, 4'd2);
    add(OpPtr, "g.ptr_final", 8'h00, 1'b0, 4'd3);

    rst_n = 1'b0;
    wait_clks(5);
    chk("reset.sda_oe", 32'(sda_oe), 32'(0));
    chk("reset.busy", 32'(busy), 32'(0));
    chk("reset.reg_addr", 32'(reg_addr), 32'(0));
    chk("reset.reg_wr_en", 32'(reg_wr_en), 32'(0));
    chk("reset.reg_rd_en", 32'(reg_rd_en), 32'(0));
    chk("reset.reg_wr_data", 32'(reg_wr_data), 32'(0));
    rst_n = 1'b1;
    wait_clks(5);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      case (v.op)
        OpStart: bus_start();
        OpStop:  bus_stop();
        OpWr, OpWrG: begin
          send_byte(v.d, v.op == OpWrG, ack);
          chk(v.nm, 32'(ack), 32'(v.x));
        end
        OpRd: begin
          recv_byte(v.x, rd);
          chk(v.nm, 32'(rd), 32'(v.d));
        end
        OpPtr:  chk(v.nm, 32'(reg_addr), 32'(v.a));
        OpBusy: chk(v.nm, 32'(busy), 32'(v.x));
        OpWlog: begin
          if (wlog_idx < wlog.size()) begin
            chk(v.nm, 32'({wlog[wlog_idx].a, wlog[wlog_idx].d}), 32'({v.a, v.d}));
            wlog_idx++;
          end else begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no write strobe seen, expected addr %0h data %0h", v.nm, v.a, v.d);
          end
        end
        OpSnap: begin
          snap_wr = wr_total;
          snap_rd = rd_total;
          snap_oe = oe_total;
        end
        OpQuiet: begin
          chk({v.nm, ".wr_strobes"}, 32'(wr_total), 32'(snap_wr));
          chk({v.nm, ".rd_strobes"}, 32'(rd_total), 32'(snap_rd));
          chk({v.nm, ".sda_oe_clks"}, 32'(oe_total), 32'(snap_oe));
        end
        default: ;
      endcase
    end

    // Reset while the slave drives the 4th bit (a 0) of register 5 = 0xE7.
    bus_start();
    send_byte(8'h84, 1'b0, ack);
    chk("rst.addr_ack", 32'(ack), 32'(1));
    send_byte(8'h05, 1'b0, ack);
    chk("rst.ptr_ack", 32'(ack), 32'(1));
    bus_start();
    send_byte(8'h85, 1'b0, ack);
    chk("rst.raddr_ack", 32'(ack), 32'(1));
    rd = 8'h00;
    for (int i = 0; i < 3; i++) begin
      recv_bit(b);
      rd[7-i] = b;
    end
    chk("rst.first_bits", 32'(rd[7:5]), 32'(3'b111));
    sda_m = 1'b1;
    wait_clks(10);
    chk("rst.bit4_driven", 32'(sda_oe), 32'(1));
    scl_m = 1'b1;
    wait_clks(5);
    snap_wr = wr_total;
    snap_rd = rd_total;
    rst_n = 1'b0;
    wait_clks(1);
    chk("rst.sda_oe", 32'(sda_oe), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.reg_addr", 32'(reg_addr), 32'(0));
    chk("rst.state", 32'(dut.state_q), 32'(StIdle));
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(5);
    scl_m = 1'b0;
    wait_clks(10);
    bus_stop();
    chk("rst.no_wr_after", 32'(wr_total), 32'(snap_wr));
    chk("rst.no_rd_after", 32'(rd_total), 32'(snap_rd));
    chk("rst.sda_oe_after", 32'(sda_oe), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
